// File: rtl/debounce_pkg.sv
// Shared constants for the input debouncer: one-hot FSM encodings, the
// rejected-bounce counter width and its saturating increment helper.
package debounce_pkg;

  // One-hot FSM state encodings (bit position identifies the state)
  localparam logic [3:0] S_LOW       = 4'b1000;
  localparam logic [3:0] S_RISE_WAIT = 4'b0100;
  localparam logic [3:0] S_HIGH      = 4'b0010;
  localparam logic [3:0] S_FALL_WAIT = 4'b0001;

  // Rejected-bounce counter geometry
  localparam int GLITCH_CNT_W = 8;
  localparam logic [GLITCH_CNT_W-1:0] GLITCH_CNT_MAX = {GLITCH_CNT_W{1'b1}};

  // Increment that sticks at the all-ones ceiling instead of wrapping
  function automatic logic [GLITCH_CNT_W-1:0] glitch_sat_inc(
    input logic [GLITCH_CNT_W-1:0] value
  );
    logic [GLITCH_CNT_W-1:0] result;
    if (value == GLITCH_CNT_MAX) begin
      result = value;
    end else begin
      result = value + GLITCH_CNT_W'(1);
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchronizer for a single asynchronous bit.
// All stages clear to 0 asynchronously while reset is low.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] stage_q;

  // Shift the raw bit through the chain; stage 0 takes the asynchronous input
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_q <= {STAGES{1'b0}};
    end else begin
      stage_q <= {stage_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/input_debounce.sv
// Switch debouncer: synchronizes raw_in, then a one-hot FSM accepts a level
// change only after DEBOUNCE_CYCLES consecutive stable samples. Outputs the
// clean level a plus one-cycle rise/fall pulses.
// Optional feature: define GLITCH_CNT_EN to add the saturating glitch_cnt
// port counting bounces that were rejected.
module input_debounce
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic a,
  output logic rise,
  output logic fall
`ifdef GLITCH_CNT_EN
  ,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_in;
  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_q, a_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (raw_in),
    .q_o   (sync_in)
  );

  // FSM next state, qualification counter and output levels/pulses
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      S_LOW: begin
        if (sync_in) begin
          state_d = S_RISE_WAIT;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = S_LOW;
        end
      end
      S_RISE_WAIT: begin
        if (!sync_in) begin
          // Bounce reverted before qualification: back to origin, level kept
          state_d = S_LOW;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_HIGH;
          a_d     = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (!sync_in) begin
          state_d = S_FALL_WAIT;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = S_HIGH;
        end
      end
      S_FALL_WAIT: begin
        if (sync_in) begin
          state_d = S_HIGH;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_LOW;
          a_d     = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        // Corrupted (non-one-hot) state: recover to a known low level quietly
        state_d = S_LOW;
        cnt_d   = {CNT_W{1'b0}};
        a_d     = 1'b0;
      end
    endcase
  end

  // FSM, counter and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_LOW;
      cnt_q   <= {CNT_W{1'b0}};
      a_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign a    = a_q;
  assign rise = rise_q;
  assign fall = fall_q;

`ifdef GLITCH_CNT_EN
  logic                    glitch_s;
  logic [GLITCH_CNT_W-1:0] glitch_cnt_q, glitch_cnt_d;

  // Flag a WAIT state falling back to its origin (a rejected bounce)
  always_comb begin
    glitch_s = 1'b0;
    if ((state_q == S_RISE_WAIT) && !sync_in) begin
      glitch_s = 1'b1;
    end else if ((state_q == S_FALL_WAIT) && sync_in) begin
      glitch_s = 1'b1;
    end else begin
      glitch_s = 1'b0;
    end
  end

  // Saturating next value of the rejected-bounce counter
  always_comb begin
    glitch_cnt_d = glitch_cnt_q;
    if (glitch_s) begin
      glitch_cnt_d = glitch_sat_inc(glitch_cnt_q);
    end else begin
      glitch_cnt_d = glitch_cnt_q;
    end
  end

  // Rejected-bounce counter register, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      glitch_cnt_q <= {GLITCH_CNT_W{1'b0}};
    end else begin
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign glitch_cnt = glitch_cnt_q;
`endif

endmodule
